// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single shared memory port.
// Alternating tie-break, CPU bus lock for AMO sequences, and a mem_ready wait timeout.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    input  logic        cpu_lock,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_fault,

    input  logic        dma_valid,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_wstrb,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    output logic        dma_fault,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2,
        LOCK_CPU = 2'd3
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_dma;
    logic        w_last_dma_nxt;
    logic [15:0] r_wait_cnt;
    logic        w_in_gnt;
    logic        w_timeout;

    assign w_in_gnt  = (r_state == GNT_CPU) || (r_state == GNT_DMA);
    assign w_timeout = w_in_gnt && !mem_ready && (r_wait_cnt == LP_CNT_LAST);

    // Counter is zero outside GNT, so every GNT entry starts from a cleared count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_last_dma <= 1'b1;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_dma <= w_last_dma_nxt;
            if (w_in_gnt && !mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_dma_nxt = r_last_dma;
        mem_valid      = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        cpu_rdata      = '0;
        cpu_ready      = 1'b0;
        cpu_fault      = 1'b0;
        dma_rdata      = '0;
        dma_ready      = 1'b0;
        dma_fault      = 1'b0;

        case (r_state)
            IDLE: begin
                if (cpu_valid && (!dma_valid || r_last_dma)) begin
                    w_state_nxt    = GNT_CPU;
                    w_last_dma_nxt = 1'b0;
                end else if (dma_valid) begin
                    w_state_nxt    = GNT_DMA;
                    w_last_dma_nxt = 1'b1;
                end
            end
            GNT_CPU: begin
                mem_valid = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wstrb = cpu_wstrb;
                if (mem_ready) begin
                    cpu_ready   = 1'b1;
                    cpu_rdata   = mem_rdata;
                    w_state_nxt = cpu_lock ? LOCK_CPU : IDLE;
                end else if (w_timeout) begin
                    cpu_ready   = 1'b1;
                    cpu_fault   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GNT_DMA: begin
                mem_valid = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_wstrb = dma_wstrb;
                if (mem_ready) begin
                    dma_ready   = 1'b1;
                    dma_rdata   = mem_rdata;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    dma_ready   = 1'b1;
                    dma_fault   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            LOCK_CPU: begin
                // A pending CPU access wins over a lock release in the same cycle.
                if (cpu_valid) begin
                    w_state_nxt    = GNT_CPU;
                    w_last_dma_nxt = 1'b0;
                end else if (!cpu_lock) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// all cycles compared against a transaction-level owner/wait model.
module tb_mem_bus_arbiter;
    localparam int T    = 4;
    localparam int NONE = 0;
    localparam int CPU  = 1;
    localparam int DMA  = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid, cpu_lock, cpu_ready, cpu_fault;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        dma_valid, dma_ready, dma_fault;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_wstrb;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_chk = 0;
    int n_err = 0;

    // Model: who owns the bus, whether the CPU holds it locked, cycles already waited.
    int m_owner;
    bit m_held;
    int m_waited;
    bit m_cpu_first;

    logic        e_mem_valid, e_cpu_ready, e_cpu_fault, e_dma_ready, e_dma_fault;
    logic [31:0] e_mem_addr, e_mem_wdata, e_cpu_rdata, e_dma_rdata;
    logic [3:0]  e_mem_wstrb;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_lock(cpu_lock), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_fault(cpu_fault),
        .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .dma_fault(dma_fault),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = NONE;
        m_held      = 1'b0;
        m_waited    = 0;
        m_cpu_first = 1'b1;
    endtask

    task automatic model_outputs();
        bit last_try;
        e_mem_valid = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_wstrb = 0;
        e_cpu_ready = 0; e_cpu_fault = 0; e_cpu_rdata = 0;
        e_dma_ready = 0; e_dma_fault = 0; e_dma_rdata = 0;
        last_try = (m_waited + 1 == T);
        if (resetn && m_owner != NONE) begin
            e_mem_valid = 1'b1;
            e_mem_addr  = (m_owner == CPU) ? cpu_addr  : dma_addr;
            e_mem_wdata = (m_owner == CPU) ? cpu_wdata : dma_wdata;
            e_mem_wstrb = (m_owner == CPU) ? cpu_wstrb : dma_wstrb;
            if (mem_ready || last_try) begin
                if (m_owner == CPU) begin
                    e_cpu_ready = 1'b1;
                    e_cpu_fault = !mem_ready;
                    e_cpu_rdata = mem_ready ? mem_rdata : 32'h0;
                end else begin
                    e_dma_ready = 1'b1;
                    e_dma_fault = !mem_ready;
                    e_dma_rdata = mem_ready ? mem_rdata : 32'h0;
                end
            end
        end
    endtask

    task automatic model_advance();
        if (!resetn) begin
            model_reset();
        end else if (m_owner != NONE) begin
            if (mem_ready) begin
                m_held  = (m_owner == CPU) && cpu_lock;
                m_owner = NONE;
            end else if (m_waited + 1 == T) begin
                m_held  = 1'b0;
                m_owner = NONE;
            end else begin
                m_waited++;
            end
        end else if (m_held) begin
            if (cpu_valid) begin
                m_owner = CPU; m_waited = 0; m_held = 1'b0; m_cpu_first = 1'b0;
            end else if (!cpu_lock) begin
                m_held = 1'b0;
            end
        end else if (cpu_valid || dma_valid) begin
            m_owner     = (cpu_valid && (!dma_valid || m_cpu_first)) ? CPU : DMA;
            m_cpu_first = (m_owner == DMA);
            m_waited    = 0;
        end
    endtask

    task automatic settle_check();
        #1;
        model_outputs();
        chk("mem_valid", 32'(mem_valid), 32'(e_mem_valid));
        chk("mem_addr",  mem_addr,  e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_mem_wstrb));
        chk("cpu_ready", 32'(cpu_ready), 32'(e_cpu_ready));
        chk("cpu_fault", 32'(cpu_fault), 32'(e_cpu_fault));
        chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
        chk("dma_ready", 32'(dma_ready), 32'(e_dma_ready));
        chk("dma_fault", 32'(dma_fault), 32'(e_dma_fault));
        chk("dma_rdata", dma_rdata, e_dma_rdata);
        chk("ready_excl", 32'(cpu_ready & dma_ready), 32'd0);
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        settle_check();
        advance();
    endtask

    task automatic idle_inputs();
        cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0; cpu_lock = 0;
        dma_valid = 0; dma_addr = 0; dma_wdata = 0; dma_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        cycle();
        resetn = 1'b1;
    endtask

    task automatic drive_random();
        if (!cpu_valid || e_cpu_ready) begin
            cpu_valid = ($urandom_range(0, 9) < 6);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
            cpu_valid = 1'b0;
        end
        if (!dma_valid || e_dma_ready) begin
            dma_valid = ($urandom_range(0, 9) < 6);
            dma_addr  = $urandom;
            dma_wdata = $urandom;
            dma_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
            dma_valid = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) cpu_lock = ~cpu_lock;
        mem_ready = ($urandom_range(0, 9) < 4);
        mem_rdata = $urandom;
    endtask

    initial begin
        int g;
        // Reset with busy inputs: every output must stay 0.
        resetn = 1'b0;
        model_reset();
        cpu_valid = 1; cpu_addr = 32'hAAAA0000; cpu_wdata = 32'h1; cpu_wstrb = 4'hF; cpu_lock = 1;
        dma_valid = 1; dma_addr = 32'hBBBB0000; dma_wdata = 32'h2; dma_wstrb = 4'h3;
        mem_ready = 1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        cycle();
        cycle();
        idle_inputs();
        resetn = 1'b1;

        // Single read, data on the 3rd granted cycle.
        cpu_valid = 1; cpu_addr = 32'h100; cpu_wstrb = 4'h0;
        settle_check(); chk("rd_c0_mvalid", 32'(mem_valid), 32'd0); advance();
        settle_check(); chk("rd_c1_mvalid", 32'(mem_valid), 32'd1);
        chk("rd_c1_addr", mem_addr, 32'h100); advance();
        settle_check(); chk("rd_c2_ready", 32'(cpu_ready), 32'd0); advance();
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        settle_check(); chk("rd_ready", 32'(cpu_ready), 32'd1);
        chk("rd_data", cpu_rdata, 32'hDEADBEEF); advance();
        cpu_valid = 0; mem_ready = 0;
        settle_check(); chk("rd_after", 32'(cpu_ready), 32'd0); advance();

        // Tie from reset: CPU, DMA, CPU, ... over 4 back-to-back pairs.
        do_reset();
        cpu_valid = 1; cpu_addr = 32'hC0; dma_valid = 1; dma_addr = 32'hD0; mem_ready = 1;
        g = 0;
        for (int k = 0; k < 16; k++) begin
            settle_check();
            if (cpu_ready || dma_ready) begin
                chk("tie_order", cpu_ready ? 32'd1 : 32'd2, (g % 2 == 0) ? 32'd1 : 32'd2);
                g++;
            end
            advance();
        end
        chk("tie_count", 32'(g), 32'd8);

        // AMO: locked read, DMA waits until the CPU write completes with lock dropped.
        do_reset();
        cpu_valid = 1; cpu_lock = 1; cpu_addr = 32'hA0; cpu_wstrb = 4'h0;
        dma_valid = 1; dma_addr = 32'hD00; dma_wstrb = 4'hF; dma_wdata = 32'h77;
        cycle();
        mem_ready = 1; mem_rdata = 32'h11;
        settle_check(); chk("amo_rd_ready", 32'(cpu_ready), 32'd1); advance();
        cpu_valid = 0; mem_ready = 0;
        settle_check(); chk("amo_c2_mvalid", 32'(mem_valid), 32'd0); advance();
        cpu_valid = 1; cpu_addr = 32'hA0; cpu_wstrb = 4'hF; cpu_wdata = 32'h12;
        settle_check(); chk("amo_c3_mvalid", 32'(mem_valid), 32'd0); advance();
        settle_check(); chk("amo_wr_addr", mem_addr, 32'hA0); advance();
        mem_ready = 1; cpu_lock = 0;
        settle_check(); chk("amo_wr_ready", 32'(cpu_ready), 32'd1); advance();
        cpu_valid = 0; mem_ready = 0;
        settle_check(); chk("amo_c6_mvalid", 32'(mem_valid), 32'd0); advance();
        mem_ready = 1;
        settle_check(); chk("amo_dma_addr", mem_addr, 32'hD00);
        chk("amo_dma_ready", 32'(dma_ready), 32'd1); advance();
        idle_inputs();
        cycle();

        // Timeout on a DMA write: ready+fault in the 4th granted cycle.
        dma_valid = 1; dma_addr = 32'h400; dma_wstrb = 4'hF; dma_wdata = 32'h9; mem_rdata = 32'h12345678;
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) dma_valid = 0;
            settle_check();
            if (k >= 1 && k <= 3) chk("to_wait_ready", 32'(dma_ready), 32'd0);
            if (k == 4) begin
                chk("to_ready", 32'(dma_ready), 32'd1);
                chk("to_fault", 32'(dma_fault), 32'd1);
                chk("to_rdata", dma_rdata, 32'd0);
            end
            if (k == 5) chk("to_idle", 32'(mem_valid), 32'd0);
            advance();
        end

        // mem_ready in exactly the timeout cycle completes normally.
        dma_valid = 1; dma_addr = 32'h500; dma_wstrb = 4'h0;
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) begin mem_ready = 1; mem_rdata = 32'hCAFEF00D; end
            settle_check();
            if (k == 4) begin
                chk("edge_ready", 32'(dma_ready), 32'd1);
                chk("edge_fault", 32'(dma_fault), 32'd0);
                chk("edge_rdata", dma_rdata, 32'hCAFEF00D);
            end
            advance();
        end
        idle_inputs();
        cycle();

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive_random();
            cycle();
        end

        // Reset during GNT_CPU, then a pending DMA request.
        idle_inputs();
        cycle();
        cpu_valid = 1; cpu_addr = 32'h600;
        cycle();
        settle_check(); chk("rst_pre_mvalid", 32'(mem_valid), 32'd1); advance();
        mem_ready = 1; mem_rdata = 32'h3; dma_valid = 1; dma_addr = 32'h700;
        resetn = 1'b0;
        settle_check();
        chk("rst_no_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mvalid", 32'(mem_valid), 32'd0);
        advance();
        cpu_valid = 0;
        cycle();
        resetn = 1'b1;
        settle_check(); chk("rst_rel_idle", 32'(mem_valid), 32'd0); advance();
        settle_check(); chk("rst_dma_gnt", 32'(mem_valid), 32'd1);
        chk("rst_dma_addr", mem_addr, 32'h700); advance();
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
